bl_block_sender: RTL and testbench

Transmit side of the dynamic-backlight path. It captures the 24 per-block 8-bit backlight levels written by the per-block averaging stage through its per-block write enables. On each frame-done strobe it snapshots them and shifts them out serially to the LED backlight driver over a clock/data/latch interface. It sits between the block-average array and the external LED driver pins.

---
 rtl/bl_block_sender.sv | 158 +++++++++++++++
 tb/tb_bl_block_sender.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bl_block_sender.sv
// Dynamic-backlight transmit path: captures per-block levels into a shadow bank and
// serialises a snapshot to the LED driver (clock/data/latch) on each frame-done request.
module bl_block_sender #(
    parameter int NUM_BLK = 24,
    parameter int DW      = 8,
    parameter int CLK_DIV = 4
) (
    input  logic                  iODCK,
    input  logic                  iRST,
    input  logic [NUM_BLK*DW-1:0] iBlockData,
    input  logic [NUM_BLK-1:0]    iWEA,
    input  logic                  iFrameDone,
    output logic                  oSCLK,
    output logic                  oSDO,
    output logic                  oLAT,
    output logic                  oBusy,
    output logic                  oOverrun
);

    localparam int TOT = NUM_BLK * DW;
    localparam int BW  = $clog2(TOT);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT, S_LATCH} state_t;

    state_t         r_state, w_state_nxt;
    logic [DW-1:0]  r_shadow [NUM_BLK];
    logic [TOT-1:0] w_shadow_flat;
    logic [TOT-1:0] r_buf;
    logic [BW-1:0]  r_bitcnt;
    logic [7:0]     r_div;
    logic           r_pend, r_sclk, r_sdo, r_lat, r_busy, r_ovr;
    logic           w_div_end, w_last_bit, w_bit_end;
    logic           w_sclk_nxt, w_sdo_nxt, w_lat_nxt;

    assign w_div_end  = (r_div == 8'(CLK_DIV - 1));
    assign w_last_bit = (r_bitcnt == '0);
    assign w_bit_end  = w_div_end && r_sclk;

    assign oSCLK    = r_sclk;
    assign oSDO     = r_sdo;
    assign oLAT     = r_lat;
    assign oBusy    = r_busy;
    assign oOverrun = r_ovr;

    // Block 0 sits at the MSB end so a left shift emits block 0 first, MSB first.
    always_comb begin
        w_shadow_flat = '0;
        for (int k = 0; k < NUM_BLK; k++)
            w_shadow_flat[TOT-1-k*DW -: DW] = r_shadow[k];
    end

    always_ff @(posedge iODCK) begin
        for (int k = 0; k < NUM_BLK; k++) begin
            if (iRST)
                r_shadow[k] <= '0;
            else if (iWEA[k])
                r_shadow[k] <= iBlockData[k*DW +: DW];
        end
    end

    always_ff @(posedge iODCK) begin
        if (iRST)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (iFrameDone) w_state_nxt = S_LOAD;
            S_LOAD:  w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_bit_end && w_last_bit) w_state_nxt = S_LATCH;
            S_LATCH: if (w_div_end) w_state_nxt = (r_pend || iFrameDone) ? S_LOAD : S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_sclk_nxt = r_sclk;
        w_sdo_nxt  = r_sdo;
        w_lat_nxt  = r_lat;
        case (r_state)
            S_LOAD: begin
                w_sclk_nxt = 1'b0;
                w_sdo_nxt  = w_shadow_flat[TOT-1];
                w_lat_nxt  = 1'b0;
            end
            S_SHIFT: begin
                if (w_div_end && !r_sclk) begin
                    w_sclk_nxt = 1'b1;
                end else if (w_bit_end && w_last_bit) begin
                    w_sclk_nxt = 1'b0;
                    w_sdo_nxt  = 1'b0;
                    w_lat_nxt  = 1'b1;
                end else if (w_bit_end) begin
                    w_sclk_nxt = 1'b0;
                    w_sdo_nxt  = r_buf[TOT-2];
                end
            end
            S_LATCH: begin
                w_sclk_nxt = 1'b0;
                w_sdo_nxt  = 1'b0;
                w_lat_nxt  = !w_div_end;
            end
            default: begin
                w_sclk_nxt = 1'b0;
                w_sdo_nxt  = 1'b0;
                w_lat_nxt  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge iODCK) begin
        if (iRST) begin
            r_sclk   <= 1'b0;
            r_sdo    <= 1'b0;
            r_lat    <= 1'b0;
            r_busy   <= 1'b0;
            r_ovr    <= 1'b0;
            r_pend   <= 1'b0;
            r_buf    <= '0;
            r_bitcnt <= '0;
            r_div    <= '0;
        end else begin
            r_sclk <= w_sclk_nxt;
            r_sdo  <= w_sdo_nxt;
            r_lat  <= w_lat_nxt;
            r_busy <= (w_state_nxt != S_IDLE);
            // In LOAD the held request is being consumed, so a new one is accepted.
            r_ovr  <= (r_state != S_IDLE) && (r_state != S_LOAD) && iFrameDone && r_pend;
            if (r_state == S_IDLE)
                r_pend <= 1'b0;
            else if (iFrameDone)
                r_pend <= 1'b1;
            else if (r_state == S_LOAD)
                r_pend <= 1'b0;

            case (r_state)
                S_LOAD: begin
                    r_buf    <= w_shadow_flat;
                    r_bitcnt <= BW'(TOT - 1);
                    r_div    <= '0;
                end
                S_SHIFT: begin
                    r_div <= w_div_end ? 8'd0 : r_div + 8'd1;
                    if (w_bit_end && !w_last_bit) begin
                        r_buf    <= {r_buf[TOT-2:0], 1'b0};
                        r_bitcnt <= r_bitcnt - 1'b1;
                    end
                end
                S_LATCH: r_div <= w_div_end ? 8'd0 : r_div + 8'd1;
                default: r_div <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_bl_block_sender.sv
// Directed bench for bl_block_sender: default-divider instance plus a CLK_DIV=1 instance.
module tb_bl_block_sender;

    localparam int NB  = 24;
    localparam int DW  = 8;
    localparam int TOT = NB * DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst, fd, sclk, sdo, lat, busy, ovr;
    logic [TOT-1:0] data;
    logic [NB-1:0]  wea;
    logic           rst1, fd1, sclk1, sdo1, lat1, busy1, ovr1;
    logic [TOT-1:0] data1;
    logic [NB-1:0]  wea1;

    bl_block_sender #(.NUM_BLK(NB), .DW(DW), .CLK_DIV(4)) dut (
        .iODCK(clk), .iRST(rst), .iBlockData(data), .iWEA(wea), .iFrameDone(fd),
        .oSCLK(sclk), .oSDO(sdo), .oLAT(lat), .oBusy(busy), .oOverrun(ovr));

    bl_block_sender #(.NUM_BLK(NB), .DW(DW), .CLK_DIV(1)) dut1 (
        .iODCK(clk), .iRST(rst1), .iBlockData(data1), .iWEA(wea1), .iFrameDone(fd1),
        .oSCLK(sclk1), .oSDO(sdo1), .oLAT(lat1), .oBusy(busy1), .oOverrun(ovr1));

    int n_checks = 0;
    int n_fail   = 0;

    logic cap_sel = 1'b0;
    logic m_sclk, m_sdo, m_lat, m_busy, m_ovr;
    assign m_sclk = cap_sel ? sclk1 : sclk;
    assign m_sdo  = cap_sel ? sdo1  : sdo;
    assign m_lat  = cap_sel ? lat1  : lat;
    assign m_busy = cap_sel ? busy1 : busy;
    assign m_ovr  = cap_sel ? ovr1  : ovr;

    bit cap_bits[$];
    int cap_busy, cap_lat, cap_latp, cap_ovr, cap_first, cap_high, cap_viol;
    bit cap_to;

    // Records one busy period, starting in the LOAD cycle (index 1).
    task automatic capture();
        logic ps, pl, pdo;
        int idx;
        ps = 1'b0; pl = 1'b0; pdo = 1'b0; idx = 0;
        cap_bits.delete();
        cap_busy = 0; cap_lat = 0; cap_latp = 0; cap_ovr = 0;
        cap_first = -1; cap_high = 0; cap_viol = 0; cap_to = 1'b0;
        while (1) begin
            @(negedge clk);
            idx++;
            if (idx > 8000) begin cap_to = 1'b1; break; end
            if (!m_busy) break;
            cap_busy++;
            if (m_lat) begin cap_lat++; if (!pl) cap_latp++; end
            if (m_sclk) cap_high++;
            if (m_sclk && !ps) begin
                cap_bits.push_back(m_sdo);
                if (cap_first < 0) cap_first = idx;
            end
            if (m_sclk && ps && (m_sdo !== pdo)) cap_viol++;
            if (m_ovr) cap_ovr++;
            ps = m_sclk; pl = m_lat; pdo = m_sdo;
        end
    endtask

    function automatic logic [7:0] blk(int f, int k);
        logic [7:0] v;
        int i;
        v = '0;
        for (int b = 0; b < 8; b++) begin
            i = f * TOT + k * DW + b;
            v = {v[6:0], (i < cap_bits.size()) ? cap_bits[i] : 1'b0};
        end
        return v;
    endfunction

    task automatic pulse_fd();
        @(posedge clk); #1 fd = 1'b1;
        @(posedge clk); #1 fd = 1'b0;
    endtask

    task automatic write_blk(int k, logic [7:0] v);
        @(posedge clk); #1 data[k*DW +: DW] = v; wea = '0; wea[k] = 1'b1;
        @(posedge clk); #1 wea = '0;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        n_checks++;
        if ({sclk, sdo, lat, busy, ovr} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs got=%b want=00000", {sclk, sdo, lat, busy, ovr});
        end
    endtask

    task automatic test_single_frame();
        @(posedge clk); #1;
        for (int k = 0; k < NB; k++) data[k*DW +: DW] = 8'(k);
        wea = '1;
        @(posedge clk); #1 wea = '0;
        pulse_fd();
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL single_busy_on_load got=%b want=1", busy); end
        capture();
        n_checks++; if (cap_to !== 1'b0) begin n_fail++; $display("FAIL single_timeout got=%0d want=0", cap_to); end
        n_checks++; if (cap_bits.size() != 192) begin n_fail++; $display("FAIL single_rises got=%0d want=192", cap_bits.size()); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (blk(0, k) !== 8'(k)) begin n_fail++; $display("FAIL single_blk%0d got=%h want=%h", k, blk(0, k), 8'(k)); end
        end
        n_checks++; if (cap_busy != 1541) begin n_fail++; $display("FAIL single_busy_len got=%0d want=1541", cap_busy); end
        n_checks++; if (cap_latp != 1) begin n_fail++; $display("FAIL single_lat_pulses got=%0d want=1", cap_latp); end
        n_checks++; if (cap_lat != 4) begin n_fail++; $display("FAIL single_lat_len got=%0d want=4", cap_lat); end
        n_checks++; if (cap_first != 6) begin n_fail++; $display("FAIL single_first_rise got=%0d want=6", cap_first); end
        n_checks++; if (cap_high != 768) begin n_fail++; $display("FAIL single_high_cycles got=%0d want=768", cap_high); end
        n_checks++; if (cap_viol != 0) begin n_fail++; $display("FAIL single_sdo_stable got=%0d want=0", cap_viol); end
        n_checks++; if (cap_ovr != 0) begin n_fail++; $display("FAIL single_overrun got=%0d want=0", cap_ovr); end
    endtask

    task automatic test_pending();
        pulse_fd();
        fork
            capture();
            begin repeat (101) @(posedge clk); pulse_fd(); end
        join
        n_checks++; if (cap_to !== 1'b0) begin n_fail++; $display("FAIL pend_timeout got=%0d want=0", cap_to); end
        n_checks++; if (cap_busy != 3082) begin n_fail++; $display("FAIL pend_busy_len got=%0d want=3082", cap_busy); end
        n_checks++; if (cap_bits.size() != 384) begin n_fail++; $display("FAIL pend_rises got=%0d want=384", cap_bits.size()); end
        n_checks++; if (cap_latp != 2) begin n_fail++; $display("FAIL pend_lat_pulses got=%0d want=2", cap_latp); end
        n_checks++; if (cap_ovr != 0) begin n_fail++; $display("FAIL pend_overrun got=%0d want=0", cap_ovr); end
        for (int k = 0; k < NB; k += 7) begin
            n_checks++;
            if (blk(1, k) !== 8'(k)) begin n_fail++; $display("FAIL pend_f2_blk%0d got=%h want=%h", k, blk(1, k), 8'(k)); end
        end
    endtask

    // Initial request starts the frame; second is queued; third finds the queue full.
    task automatic test_overrun();
        pulse_fd();
        fork
            capture();
            begin
                repeat (100) @(posedge clk);
                pulse_fd();
                n_checks++; if (ovr !== 1'b0) begin n_fail++; $display("FAIL ovr_second_req got=%b want=0", ovr); end
                repeat (100) @(posedge clk);
                pulse_fd();
                n_checks++; if (ovr !== 1'b1) begin n_fail++; $display("FAIL ovr_third_req got=%b want=1", ovr); end
            end
        join
        n_checks++; if (cap_ovr != 1) begin n_fail++; $display("FAIL ovr_count got=%0d want=1", cap_ovr); end
        n_checks++; if (cap_busy != 3082) begin n_fail++; $display("FAIL ovr_busy_len got=%0d want=3082", cap_busy); end
        n_checks++; if (cap_bits.size() != 384) begin n_fail++; $display("FAIL ovr_rises got=%0d want=384", cap_bits.size()); end
        n_checks++; if (cap_latp != 2) begin n_fail++; $display("FAIL ovr_lat_pulses got=%0d want=2", cap_latp); end
    endtask

    task automatic test_collision();
        write_blk(5, 8'h11);
        @(posedge clk); #1 data[5*DW +: DW] = 8'hAA; wea = '0; wea[5] = 1'b1; fd = 1'b1;
        @(posedge clk); #1 wea = '0; fd = 1'b0;
        fork
            capture();
            begin
                repeat (200) @(posedge clk);
                #1 data[5*DW +: DW] = 8'h55; wea[5] = 1'b1;
                @(posedge clk); #1 wea = '0;
            end
        join
        n_checks++; if (blk(0, 5) !== 8'hAA) begin n_fail++; $display("FAIL coll_blk5 got=%h want=aa", blk(0, 5)); end
        n_checks++; if (blk(0, 4) !== 8'h04) begin n_fail++; $display("FAIL coll_blk4 got=%h want=04", blk(0, 4)); end
        n_checks++; if (blk(0, 6) !== 8'h06) begin n_fail++; $display("FAIL coll_blk6 got=%h want=06", blk(0, 6)); end
        pulse_fd();
        capture();
        n_checks++; if (blk(0, 5) !== 8'h55) begin n_fail++; $display("FAIL coll_next_blk5 got=%h want=55", blk(0, 5)); end
        n_checks++; if (blk(0, 23) !== 8'h17) begin n_fail++; $display("FAIL coll_next_blk23 got=%h want=17", blk(0, 23)); end
    endtask

    task automatic test_reset_mid();
        int bad;
        pulse_fd();
        repeat (401) @(posedge clk);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL rstmid_busy_before got=%b want=1", busy); end
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        n_checks++;
        if ({sclk, sdo, lat, busy, ovr} !== 5'b0) begin
            n_fail++; $display("FAIL rstmid_outputs got=%b want=00000", {sclk, sdo, lat, busy, ovr});
        end
        bad = 0;
        repeat (1700) begin @(negedge clk); if (lat !== 1'b0 || busy !== 1'b0) bad++; end
        n_checks++; if (bad != 0) begin n_fail++; $display("FAIL rstmid_no_latch got=%0d want=0", bad); end
        pulse_fd();
        capture();
        n_checks++; if (cap_bits.size() != 192) begin n_fail++; $display("FAIL rstmid_rises got=%0d want=192", cap_bits.size()); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (blk(0, k) !== 8'h00) begin n_fail++; $display("FAIL rstmid_blk%0d got=%h want=00", k, blk(0, k)); end
        end
        n_checks++; if (cap_busy != 1541) begin n_fail++; $display("FAIL rstmid_busy_len got=%0d want=1541", cap_busy); end
        n_checks++; if (cap_latp != 1) begin n_fail++; $display("FAIL rstmid_lat_pulses got=%0d want=1", cap_latp); end
    endtask

    task automatic test_clkdiv1();
        @(posedge clk); #1 rst1 = 1'b0;
        n_checks++;
        if ({sclk1, sdo1, lat1, busy1, ovr1} !== 5'b0) begin
            n_fail++; $display("FAIL div1_reset got=%b want=00000", {sclk1, sdo1, lat1, busy1, ovr1});
        end
        for (int k = 0; k < NB; k++) data1[k*DW +: DW] = 8'(k + 8'h40);
        wea1 = '1;
        @(posedge clk); #1 wea1 = '0; fd1 = 1'b1;
        @(posedge clk); #1 fd1 = 1'b0;
        cap_sel = 1'b1;
        capture();
        cap_sel = 1'b0;
        n_checks++; if (cap_bits.size() != 192) begin n_fail++; $display("FAIL div1_rises got=%0d want=192", cap_bits.size()); end
        for (int k = 0; k < NB; k++) begin
            n_checks++;
            if (blk(0, k) !== 8'(k + 8'h40)) begin n_fail++; $display("FAIL div1_blk%0d got=%h want=%h", k, blk(0, k), 8'(k + 8'h40)); end
        end
        n_checks++; if (cap_busy != 386) begin n_fail++; $display("FAIL div1_busy_len got=%0d want=386", cap_busy); end
        n_checks++; if (cap_lat != 1) begin n_fail++; $display("FAIL div1_lat_len got=%0d want=1", cap_lat); end
        n_checks++; if (cap_first != 3) begin n_fail++; $display("FAIL div1_first_rise got=%0d want=3", cap_first); end
        n_checks++; if (cap_high != 192) begin n_fail++; $display("FAIL div1_high_cycles got=%0d want=192", cap_high); end
        n_checks++; if (cap_viol != 0) begin n_fail++; $display("FAIL div1_sdo_stable got=%0d want=0", cap_viol); end
    endtask

    initial begin
        rst = 1'b1; fd = 1'b0; data = '0; wea = '0;
        rst1 = 1'b1; fd1 = 1'b0; data1 = '0; wea1 = '0;
        test_reset();
        test_single_frame();
        test_pending();
        test_overrun();
        test_collision();
        test_reset_mid();
        test_clkdiv1();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
